ctrl_conv: RTL and testbench
============================

Name: ctrl_conv

Overview:
- Convolution-stage controller directly downstream of the core controller.
- Consumes the core's delayed control bus (start/valid/stop) and the pixel-raster context (image size, filter size, first/last input flags, core state).
- Decides which raster positions carry a complete fil_size×fil_size window and delays control through the multiply/adder-tree pipeline.
- Emits accumulation-buffer control plus a pipelined control bus for the next (activation/pool) stage.

Parameters:
- LWIDTH, 10, width of size and coordinate fields.
- OUTSIZE, 10, accumulation-buffer address width.
- D_CONV, 6, latency of the multiplier + adder tree in cycles (≥1).

Ports:
- clk  in  1  clock.
- xrst  in  1  synchronous, active-high reset.
- in_ctrl  in  ctrl_bus (start, valid, stop)  control from core stage.
- core_state  in  2  core phase: 0 WAIT, 1 NETWORK, 2 INPUT, 3 OUTPUT.
- w_img_size  in  LWIDTH  image edge length.
- w_fil_size  in  LWIDTH  filter edge length.
- first_input  in  1  current pass is input channel 0.
- last_input  in  1  current pass is the final input channel.
- out_ctrl  out  ctrl_bus  control to next stage, D_CONV cycles after window decision.
- accum_we  out  1  write conv result into accumulation buffer.
- accum_clr  out  1  overwrite instead of add (first channel).
- accum_addr  out  OUTSIZE  accumulation-buffer address.
- bias_en  out  1  add bias on this write (last channel).

Behaviour:
- Reset: all outputs 0, FSM in S_IDLE, counters 0, delay lines cleared.
- FSM states and transitions:
  - S_IDLE → S_RUN on in_ctrl.start while core_state==INPUT. Sizes latch on this start.
  - S_RUN → S_DRAIN on in_ctrl.stop.
  - S_DRAIN counts D_CONV cycles, then → S_IDLE.
  - start in S_DRAIN: accepted, goes to S_RUN; in-flight pipeline entries still retire.
- Start outside core_state==INPUT (network phase): forwarded to out_ctrl.start only; no counting.
- Raster counters x, y:
  - Zeroed on accepted start.
  - On in_ctrl.valid in S_RUN: x increments; at x==img-1, x wraps to 0 and y increments; at y==img-1 and x==img-1, both wrap to 0.
- Window valid: win = valid && x ≥ fil-1 && y ≥ fil-1, computed combinationally from the pre-increment x, y. Gives (img-fil+1)² windows per pass.
- Address counter:
  - Cleared on accepted start.
  - Increments by 1 per win; wraps 2^OUTSIZE → 0, which is undetected in the base build.
- Delay stage (D_CONV deep) carries win, first_input, last_input, addr and the start/valid/stop bits.
- Outputs at pipeline tail:
  - accum_we = win; accum_clr = first && win; bias_en = last && win; accum_addr = addr.
  - out_ctrl.valid = win; out_ctrl.start/stop = delayed in start/stop.
- Total latency from an input valid to its accum_we is D_CONV+1 cycles (one register, then D_CONV stages).
- start and stop in the same cycle: treated as a zero-length pass. No win pulses; out start and stop are each delayed normally.
- Valid in S_IDLE: ignored, no counter change.
- Reset mid-pass: pipeline flushed, no residual pulses.
- Size changes mid-pass: ignored until the next accepted start.

Optional Feature:
- Macro CTRL_CONV_CHECK_EN adds output conv_err (1 bit, sticky until reset).
- conv_err sets when either occurs:
  - stop arrives with valid count ≠ img²;
  - fil > img at start.
- Without the macro, the port and checker logic are absent.

Decomposition:
- Shared package renkon_pkg holds:
  - LWIDTH, OUTSIZE, D_CONV, CORE;
  - core-state encoding typedef (WAIT/NETWORK/INPUT/OUTPUT);
  - ctrl_reg struct {start, valid, stop}; the ctrl_bus interface is reused.
- Sub-module ctrl_delay: parametric-depth shift register of a packed payload, used for the D_CONV pipeline.

Test Plan:
- img=12, fil=5, INPUT phase, 144 valids → 64 accum_we pulses, addr 0..63; first at input index 52 (+D_CONV+1 cycles), last at index 143.
- Same pass with first_input=1, last_input=0 → accum_clr on all 64 writes, bias_en never asserted; repeat with last_input=1 → bias_en on all 64 writes.
- start during NETWORK phase with 25 valids → out_ctrl.start forwarded after D_CONV+1 cycles, zero accum_we, addr stays 0.
- Simultaneous start+stop → out start and stop pulses D_CONV+1 cycles later, no valid/accum_we.
- Assert xrst after 80 of 144 valids → all outputs 0 next cycle, no accum_we thereafter; a fresh pass restarts at addr 0.
- CTRL_CONV_CHECK_EN: stop after 143 valids (img=12) → conv_err=1 and stays 1; fil=13, img=12 → conv_err=1 at start.

Source files
------------

// File: rtl/renkon_pkg.sv
// Shared definitions for the renkon convolution datapath controllers:
// default geometry parameters, core phase encoding, the control bus record
// and the convolution-controller FSM states.
package renkon_pkg;

    localparam int LWIDTH  = 10;
    localparam int OUTSIZE = 10;
    localparam int D_CONV  = 6;
    localparam int CORE    = 8;

    // Phase reported by the core controller
    typedef enum logic [1:0] {
        CORE_WAIT    = 2'd0,
        CORE_NETWORK = 2'd1,
        CORE_INPUT   = 2'd2,
        CORE_OUTPUT  = 2'd3
    } core_state_t;

    // Control bus passed from stage to stage along the pipeline
    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;

    localparam ctrl_reg CTRL_IDLE = '{start: 1'b0, valid: 1'b0, stop: 1'b0};

    // Convolution controller FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } conv_state_t;

    // True when a start on the control bus opens a counted convolution pass
    function automatic logic start_accepted(input ctrl_reg c, input logic [1:0] phase);
        return c.start && (phase == CORE_INPUT);
    endfunction

endpackage

// File: rtl/ctrl_conv_delay.sv
// ctrl_delay: fixed-depth shift register for a packed payload. It models the
// multiplier + adder-tree latency so control arrives together with the data.
module ctrl_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the payload one stage per cycle; reset flushes every stage
    always_ff @(posedge clk) begin
        if (xrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/ctrl_conv.sv
// ctrl_conv: convolution-stage controller. Tracks the raster position of each
// incoming pixel, flags positions that complete a fil x fil window, and delays
// that decision through the multiply/adder-tree latency to drive the
// accumulation buffer and the control bus of the following stage.
// Optional build macro CTRL_CONV_CHECK_EN adds the sticky conv_err output.
module ctrl_conv #(
    parameter int LWIDTH  = renkon_pkg::LWIDTH,
    parameter int OUTSIZE = renkon_pkg::OUTSIZE,
    parameter int D_CONV  = renkon_pkg::D_CONV
) (
    input  logic                clk,
    input  logic                xrst,
    input  renkon_pkg::ctrl_reg in_ctrl,
    input  logic [1:0]          core_state,
    input  logic [LWIDTH-1:0]   w_img_size,
    input  logic [LWIDTH-1:0]   w_fil_size,
    input  logic                first_input,
    input  logic                last_input,
    output renkon_pkg::ctrl_reg out_ctrl,
    output logic                accum_we,
    output logic                accum_clr,
    output logic [OUTSIZE-1:0]  accum_addr,
    output logic                bias_en
`ifdef CTRL_CONV_CHECK_EN
    ,
    output logic                conv_err
`endif
);

    import renkon_pkg::*;

    localparam int DCW = (D_CONV > 1) ? $clog2(D_CONV) : 1;
    localparam int PW  = OUTSIZE + 5;

    conv_state_t         r_state;
    conv_state_t         w_state_n;
    logic [LWIDTH-1:0]   r_x;
    logic [LWIDTH-1:0]   r_y;
    logic [LWIDTH-1:0]   r_img;
    logic [LWIDTH-1:0]   r_fil;
    logic [LWIDTH-1:0]   w_x_n;
    logic [LWIDTH-1:0]   w_y_n;
    logic [LWIDTH-1:0]   w_img_n;
    logic [LWIDTH-1:0]   w_fil_n;
    logic [LWIDTH-1:0]   w_imgm1;
    logic [LWIDTH-1:0]   w_film1;
    logic [OUTSIZE-1:0]  r_addr;
    logic [OUTSIZE-1:0]  w_addr_n;
    logic [DCW-1:0]      r_drain;
    logic [DCW-1:0]      w_drain_n;
    logic                w_accept;
    logic                w_run;
    logic                w_win;
    logic [PW-1:0]       w_pay_head;
    logic [PW-1:0]       r_pay;
    logic [PW-1:0]       w_pay_tail;
    logic                w_tail_win;
    logic                w_tail_first;
    logic                w_tail_last;
    logic                w_tail_start;
    logic                w_tail_stop;
    logic [OUTSIZE-1:0]  w_tail_addr;

    assign w_accept = start_accepted(in_ctrl, core_state);
    assign w_run    = (r_state == S_RUN);
    assign w_imgm1  = r_img - LWIDTH'(1);
    assign w_film1  = r_fil - LWIDTH'(1);

    // A window completes when the current (pre-increment) raster position has
    // at least fil-1 pixels to its left and above. A restarting start wins
    // over a coincident valid, since the counters are being zeroed.
    assign w_win = w_run && in_ctrl.valid && !w_accept &&
                   (r_x >= w_film1) && (r_y >= w_film1);

    // Next-state, raster counters, address counter and drain timer
    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_img_n   = r_img;
        w_fil_n   = r_fil;
        w_addr_n  = r_addr;
        w_drain_n = '0;

        if (w_accept) begin
            w_state_n = in_ctrl.stop ? S_DRAIN : S_RUN;
            w_x_n     = '0;
            w_y_n     = '0;
            w_addr_n  = '0;
            w_img_n   = w_img_size;
            w_fil_n   = w_fil_size;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (in_ctrl.valid) begin
                        if (r_x == w_imgm1) begin
                            w_x_n = '0;
                            if (r_y == w_imgm1) begin
                                w_y_n = '0;
                            end else begin
                                w_y_n = r_y + LWIDTH'(1);
                            end
                        end else begin
                            w_x_n = r_x + LWIDTH'(1);
                        end
                    end
                    if (w_win) begin
                        w_addr_n = r_addr + OUTSIZE'(1);
                    end
                    if (in_ctrl.stop) begin
                        w_state_n = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DCW'(D_CONV - 1)) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_drain_n = r_drain + DCW'(1);
                    end
                end
                default: begin
                    w_state_n = r_state;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_img   <= '0;
            r_fil   <= '0;
            r_addr  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_img   <= w_img_n;
            r_fil   <= w_fil_n;
            r_addr  <= w_addr_n;
            r_drain <= w_drain_n;
        end
    end

    // Address is only meaningful alongside a write, so it is zeroed otherwise
    // to keep the accumulation-buffer port quiet between writes.
    assign w_pay_head = {w_win, first_input, last_input,
                         in_ctrl.start, in_ctrl.stop,
                         (w_win ? r_addr : OUTSIZE'(0))};

    // Decision register ahead of the multiply/adder-tree delay line
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_pay <= '0;
        end else begin
            r_pay <= w_pay_head;
        end
    end

    ctrl_delay #(
        .DEPTH (D_CONV),
        .WIDTH (PW)
    ) u_delay (
        .clk    (clk),
        .xrst   (xrst),
        .i_data (r_pay),
        .o_data (w_pay_tail)
    );

    assign {w_tail_win, w_tail_first, w_tail_last,
            w_tail_start, w_tail_stop, w_tail_addr} = w_pay_tail;

    assign accum_we   = w_tail_win;
    assign accum_clr  = w_tail_first && w_tail_win;
    assign bias_en    = w_tail_last && w_tail_win;
    assign accum_addr = w_tail_addr;
    assign out_ctrl   = '{start: w_tail_start, valid: w_tail_win, stop: w_tail_stop};

`ifdef CTRL_CONV_CHECK_EN
    logic [2*LWIDTH-1:0] r_cnt;
    logic [2*LWIDTH-1:0] w_cnt_n;
    logic [2*LWIDTH-1:0] w_cnt_stop;
    logic [2*LWIDTH-1:0] w_img_sq;
    logic                r_err;
    logic                w_err_n;

    assign w_img_sq = (2*LWIDTH)'(r_img) * (2*LWIDTH)'(r_img);

    // Count valids of the running pass and flag short/long passes or a
    // filter larger than the image. Only a stop that ends a running pass is
    // judged; a start+stop pair is a deliberate empty pass.
    always_comb begin
        w_cnt_n    = r_cnt;
        w_err_n    = r_err;
        w_cnt_stop = r_cnt + (2*LWIDTH)'(in_ctrl.valid);
        if (w_accept) begin
            w_cnt_n = '0;
            if (w_fil_size > w_img_size) begin
                w_err_n = 1'b1;
            end
        end else if (w_run) begin
            w_cnt_n = w_cnt_stop;
            if (in_ctrl.stop && (w_cnt_stop != w_img_sq)) begin
                w_err_n = 1'b1;
            end
        end
    end

    // Valid counter and sticky error flag
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_n;
            r_err <= w_err_n;
        end
    end

    assign conv_err = r_err;
`endif

endmodule

// File: tb/tb_ctrl_conv.sv
// tb_ctrl_conv: scoreboard bench for ctrl_conv. Stimulus pushes the expected
// output record (with the cycle it must appear) into a queue; a monitor on the
// falling edge pops and compares whenever the DUT presents any output.
module tb_ctrl_conv;
    import renkon_pkg::*;

    localparam int LW = LWIDTH;
    localparam int OS = OUTSIZE;
    localparam int DC = D_CONV;

    typedef struct packed {
        logic          start;
        logic          valid;
        logic          stop;
        logic          we;
        logic          clr;
        logic          bias;
        logic [OS-1:0] addr;
    } obs_t;

    typedef struct {
        obs_t o;
        int   due;
    } exp_t;

    logic          clk = 1'b0;
    logic          xrst;
    ctrl_reg       in_ctrl;
    ctrl_reg       out_ctrl;
    logic [1:0]    core_state;
    logic [LW-1:0] w_img_size;
    logic [LW-1:0] w_fil_size;
    logic          first_input;
    logic          last_input;
    logic          accum_we;
    logic          accum_clr;
    logic [OS-1:0] accum_addr;
    logic          bias_en;
`ifdef CTRL_CONV_CHECK_EN
    logic          conv_err;
`endif

    exp_t sbq[$];
    obs_t got;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   monEn = 1'b0;
    int   nWe = 0;
    int   maxAddr = 0;
    int   firstWeCyc = 0;
    int   lastWeCyc = 0;
    int   passStart = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ctrl_conv #(
        .LWIDTH  (LW),
        .OUTSIZE (OS),
        .D_CONV  (DC)
    ) dut (
        .clk         (clk),
        .xrst        (xrst),
        .in_ctrl     (in_ctrl),
        .core_state  (core_state),
        .w_img_size  (w_img_size),
        .w_fil_size  (w_fil_size),
        .first_input (first_input),
        .last_input  (last_input),
        .out_ctrl    (out_ctrl),
        .accum_we    (accum_we),
        .accum_clr   (accum_clr),
        .accum_addr  (accum_addr),
        .bias_en     (bias_en)
`ifdef CTRL_CONV_CHECK_EN
        ,
        .conv_err    (conv_err)
`endif
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the control bus for one cycle, just after the rising edge
    task automatic applyStimulus(input logic s, input logic v, input logic st);
        @(posedge clk);
        #1;
        in_ctrl = '{start: s, valid: v, stop: st};
    endtask

    task automatic pushExp(input logic s, input logic v, input logic st, input logic we,
                           input logic clr, input logic bias, input logic [OS-1:0] a);
        exp_t e;
        e.o   = '{start: s, valid: v, stop: st, we: we, clr: clr, bias: bias, addr: a};
        e.due = cyc + 1 + DC;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic purgeAfter(input int k);
        exp_t keep[$];
        foreach (sbq[i]) if (sbq[i].due <= k) keep.push_back(sbq[i]);
        sbq = keep;
    endtask

    task automatic checkZero(input string name);
        checkOutput(name, longint'({out_ctrl, accum_we, accum_clr, bias_en, accum_addr}), 0);
    endtask

    // Synchronous reset pulse; anything still in flight is discarded
    task automatic doReset();
        @(posedge clk);
        #1;
        xrst    = 1'b1;
        in_ctrl = CTRL_IDLE;
        purgeAfter(cyc);
        @(posedge clk);
        #1;
        xrst = 1'b0;
    endtask

    // One pass: start, nValid valids (gap idle cycles after each), optional stop
    task automatic runPass(input int img, input int fil, input bit first, input bit last,
                           input logic [1:0] phase, input int nValid, input int gap,
                           input bit doStop);
        int addr;
        addr        = 0;
        nWe         = 0;
        maxAddr     = 0;
        w_img_size  = LW'(img);
        w_fil_size  = LW'(fil);
        first_input = first;
        last_input  = last;
        core_state  = phase;
        applyStimulus(1'b1, 1'b0, 1'b0);
        passStart = cyc;
        pushExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < nValid; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (phase == CORE_INPUT && (i % img) >= fil - 1 && (i / img) >= fil - 1) begin
                pushExp(1'b0, 1'b1, 1'b0, 1'b1, first, last, OS'(addr));
                addr++;
            end
            idle(gap);
        end
        if (doStop) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            pushExp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
        idle(DC + 4);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (monEn) begin
            got = '{start: out_ctrl.start, valid: out_ctrl.valid, stop: out_ctrl.stop,
                    we: accum_we, clr: accum_clr, bias: bias_en, addr: accum_addr};
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                checkOutput("missing_output_due", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (got.start || got.valid || got.stop || got.we) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_output", longint'(got), 0);
                end else begin
                    checkOutput("output_cycle", cyc, sbq[0].due);
                    checkOutput("output_fields", longint'(got), longint'(sbq[0].o));
                    void'(sbq.pop_front());
                end
                if (got.we) begin
                    if (nWe == 0) firstWeCyc = cyc;
                    lastWeCyc = cyc;
                    nWe++;
                    if (int'(got.addr) > maxAddr) maxAddr = int'(got.addr);
                end
            end
        end
    end

    initial begin
        xrst        = 1'b1;
        in_ctrl     = CTRL_IDLE;
        core_state  = CORE_WAIT;
        w_img_size  = '0;
        w_fil_size  = '0;
        first_input = 1'b0;
        last_input  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        xrst = 1'b0;
        @(negedge clk);
        checkZero("reset_state");
`ifdef CTRL_CONV_CHECK_EN
        checkOutput("reset_conv_err", conv_err, 0);
`endif
        monEn = 1'b1;

        // 12x12 image, 5x5 filter: 64 windows, first at index 52, last at 143
        runPass(12, 5, 1'b0, 1'b0, CORE_INPUT, 144, 0, 1'b1);
        checkOutput("pass1_we_count", nWe, 64);
        checkOutput("pass1_max_addr", maxAddr, 63);
        checkOutput("pass1_first_we_latency", firstWeCyc - passStart, 53 + 1 + DC);
        checkOutput("pass1_last_we_latency", lastWeCyc - passStart, 144 + 1 + DC);

        // First channel: every write clears
        runPass(12, 5, 1'b1, 1'b0, CORE_INPUT, 144, 0, 1'b1);
        checkOutput("pass_first_we_count", nWe, 64);

        // Last channel, valids with one idle cycle between them: bias on every write
        runPass(12, 5, 1'b0, 1'b1, CORE_INPUT, 144, 1, 1'b1);
        checkOutput("pass_last_we_count", nWe, 64);
        checkOutput("pass_last_max_addr", maxAddr, 63);

        // Network phase: start/stop forwarded, no counting
        runPass(12, 5, 1'b0, 1'b0, CORE_NETWORK, 25, 0, 1'b1);
        checkOutput("network_we_count", nWe, 0);
        checkOutput("network_addr", accum_addr, 0);

        // Zero-length pass, then valids while idle must be ignored
        core_state = CORE_INPUT;
        applyStimulus(1'b1, 1'b0, 1'b1);
        pushExp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(DC + 4);
        nWe = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        idle(DC + 4);
        checkOutput("idle_valid_we_count", nWe, 0);

        // Reset after 80 of 144 valids
        runPass(12, 5, 1'b0, 1'b0, CORE_INPUT, 80, 0, 1'b0);
        doReset();
        @(negedge clk);
        checkZero("midpass_reset_outputs");
        nWe = 0;
        idle(DC + 4);
        checkOutput("after_reset_we_count", nWe, 0);

        // Fresh pass restarts at address 0
        runPass(12, 5, 1'b0, 1'b0, CORE_INPUT, 144, 0, 1'b1);
        checkOutput("fresh_we_count", nWe, 64);
        checkOutput("fresh_max_addr", maxAddr, 63);
        checkOutput("fresh_first_we_latency", firstWeCyc - passStart, 53 + 1 + DC);

`ifdef CTRL_CONV_CHECK_EN
        checkOutput("err_clean_before", conv_err, 0);
        runPass(12, 5, 1'b0, 1'b0, CORE_INPUT, 143, 0, 1'b1);
        checkOutput("err_short_pass", conv_err, 1);
        idle(5);
        checkOutput("err_sticky", conv_err, 1);
        doReset();
        @(negedge clk);
        checkOutput("err_cleared_by_reset", conv_err, 0);
        w_img_size = LW'(12);
        w_fil_size = LW'(13);
        core_state = CORE_INPUT;
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err_fil_gt_img", conv_err, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushExp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(DC + 4);
`endif

        checkOutput("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
